// File: rtl/des_req_ctrl.sv
`timescale 1ns/1ps
// des_req_ctrl: host-side job FIFO plus a single-outstanding request FSM for the DES core.
// Define DES_REQ_STATS_EN to add saturating job, error and timeout counters.

module des_req_ctrl #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_data,
    input  logic [63:0] req_key,
    input  logic        req_mode,
    input  logic        req_verify,
    output logic [63:0] des_data,
    output logic [63:0] des_key,
    output logic        des_mode,
    output logic        des_verify,
    output logic        des_in_valid,
    input  logic        des_ready,
    input  logic [63:0] des_out,
    input  logic        des_out_valid,
    input  logic        des_err,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_err,
    output logic        rsp_timeout,
`ifdef DES_REQ_STATS_EN
    output logic [31:0] stat_jobs,
    output logic [15:0] stat_errs,
    output logic [15:0] stat_tmo,
`endif
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef struct packed {
        logic [63:0] data;
        logic [63:0] key;
        logic        mode;
        logic        verify;
    } job_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // ---------------------------------------------------------------
    // Job FIFO
    // ---------------------------------------------------------------
    job_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_req_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    job_t          w_in_job;
    job_t          w_head;

    assign w_push   = req_valid && r_req_ready;
    assign w_empty  = (r_count == '0);
    assign w_in_job = '{data: req_data, key: req_key, mode: req_mode, verify: req_verify};
    assign w_head   = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_job;
        end
    end

    // req_ready is registered from the post-update count, so it is low exactly while full
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_req_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count     <= w_count_nxt;
            r_req_ready <= (w_count_nxt != FULL_CNT);
        end
    end

    // ---------------------------------------------------------------
    // Request FSM
    // ---------------------------------------------------------------
    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_hs;
    logic          w_capture;
    logic          w_expire;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_des_in_valid;
    job_t          r_des_job;
    logic          r_rsp_valid;
    logic [63:0]   r_rsp_data;
    logic          r_rsp_err;
    logic          r_rsp_timeout;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_hs        = 1'b0;
        w_capture   = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_des_in_valid && des_ready) begin
                    w_hs        = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result arriving in the expiry cycle takes priority over the timeout
                if (des_out_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_expire    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Core-side request registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_des_job      <= '0;
            r_des_in_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                r_des_job      <= w_head;
                r_des_in_valid <= 1'b1;
            end else if (w_hs) begin
                r_des_in_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tmo_cnt <= '0;
        end else begin
            if (w_hs) begin
                r_tmo_cnt <= '0;
            end else if ((r_state == S_WAIT) && !w_capture && !w_expire) begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // Response registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_capture) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_data    <= des_out;
                r_rsp_err     <= des_err;
                r_rsp_timeout <= 1'b0;
            end else if (w_expire) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_data    <= '0;
                r_rsp_err     <= 1'b0;
                r_rsp_timeout <= 1'b1;
            end else if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef DES_REQ_STATS_EN
    logic [31:0] r_stat_jobs;
    logic [15:0] r_stat_errs;
    logic [15:0] r_stat_tmo;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_stat_jobs <= '0;
            r_stat_errs <= '0;
            r_stat_tmo  <= '0;
        end else begin
            if (w_hs && (r_stat_jobs != '1)) begin
                r_stat_jobs <= r_stat_jobs + 32'd1;
            end
            if (w_capture && des_err && (r_stat_errs != '1)) begin
                r_stat_errs <= r_stat_errs + 16'd1;
            end
            if (w_expire && (r_stat_tmo != '1)) begin
                r_stat_tmo <= r_stat_tmo + 16'd1;
            end
        end
    end

    assign stat_jobs = r_stat_jobs;
    assign stat_errs = r_stat_errs;
    assign stat_tmo  = r_stat_tmo;
`endif

    assign req_ready    = r_req_ready;
    assign des_data     = r_des_job.data;
    assign des_key      = r_des_job.key;
    assign des_mode     = r_des_job.mode;
    assign des_verify   = r_des_job.verify;
    assign des_in_valid = r_des_in_valid;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_err      = r_rsp_err;
    assign rsp_timeout  = r_rsp_timeout;
    assign busy         = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_des_req_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for des_req_ctrl: expected issues/responses are queued at push time,
// a behavioural core model answers handshakes and a monitor checks each response.

module tb_des_req_ctrl;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 64;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_data = '0;
    logic [63:0] req_key = '0;
    logic        req_mode = 1'b0;
    logic        req_verify = 1'b0;
    logic [63:0] des_data;
    logic [63:0] des_key;
    logic        des_mode;
    logic        des_verify;
    logic        des_in_valid;
    logic        des_ready = 1'b1;
    logic [63:0] des_out = '0;
    logic        des_out_valid = 1'b0;
    logic        des_err = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;
`ifdef DES_REQ_STATS_EN
    logic [31:0] stat_jobs;
    logic [15:0] stat_errs;
    logic [15:0] stat_tmo;
`endif

    always #5 clk_in = ~clk_in;

    des_req_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .req_key       (req_key),
        .req_mode      (req_mode),
        .req_verify    (req_verify),
        .des_data      (des_data),
        .des_key       (des_key),
        .des_mode      (des_mode),
        .des_verify    (des_verify),
        .des_in_valid  (des_in_valid),
        .des_ready     (des_ready),
        .des_out       (des_out),
        .des_out_valid (des_out_valid),
        .des_err       (des_err),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .rsp_timeout   (rsp_timeout),
`ifdef DES_REQ_STATS_EN
        .stat_jobs     (stat_jobs),
        .stat_errs     (stat_errs),
        .stat_tmo      (stat_tmo),
`endif
        .busy          (busy)
    );

    typedef struct {
        logic [63:0] data;
        logic [63:0] key;
        logic        mode;
        logic        verify;
    } job_t;

    // lat > 0: core answers lat cycles after the handshake; lat == 0: no answer,
    // optionally a stray pulse 'late' cycles after the handshake.
    typedef struct {
        int          lat;
        logic [63:0] out;
        logic        err;
        int          late;
    } beh_t;

    typedef struct {
        logic [63:0] data;
        logic        err;
        logic        tmo;
    } rsp_t;

    job_t iss_q[$];
    beh_t beh_q[$];
    rsp_t rsp_q[$];

    int n_checks   = 0;
    int n_pass     = 0;
    int dv_cycles  = 0;
    int rsp_cycles = 0;

    function automatic job_t mkj(input logic [63:0] d, input logic [63:0] k,
                                 input logic m, input logic v);
        job_t j;
        j.data = d; j.key = k; j.mode = m; j.verify = v;
        return j;
    endfunction

    function automatic beh_t mkb(input int lat, input logic [63:0] o,
                                 input logic e, input int late);
        beh_t b;
        b.lat = lat; b.out = o; b.err = e; b.late = late;
        return b;
    endfunction

    function automatic rsp_t mkr(input logic [63:0] d, input logic e, input logic t);
        rsp_t r;
        r.data = d; r.err = e; r.tmo = t;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name, input string what);
        n_checks++;
        $display("FAIL %s: got %s, expected none", name, what);
    endtask

    task automatic core_model();
        job_t j;
        beh_t b;
        forever begin
            @(negedge clk_in);
            if (rst_n_in && des_in_valid && des_ready) begin
                if (iss_q.size() == 0 || beh_q.size() == 0) begin
                    fail_event("issue_order", "handshake with no queued job");
                end else begin
                    j = iss_q.pop_front();
                    b = beh_q.pop_front();
                    check("iss_data", des_data, j.data);
                    check("iss_key", des_key, j.key);
                    check("iss_mode_verify", {62'd0, des_mode, des_verify}, {62'd0, j.mode, j.verify});
                    @(posedge clk_in);
                    if (b.lat > 0) begin
                        repeat (b.lat - 1) @(posedge clk_in);
                        #1;
                        des_out = b.out; des_err = b.err; des_out_valid = 1'b1;
                        @(posedge clk_in);
                        #1;
                        des_out_valid = 1'b0; des_err = 1'b0;
                    end else if (b.late > 0) begin
                        repeat (b.late - 1) @(posedge clk_in);
                        #1;
                        des_out = 64'hDEAD_BEEF_DEAD_BEEF; des_err = 1'b0; des_out_valid = 1'b1;
                        @(posedge clk_in);
                        #1;
                        des_out_valid = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic rsp_monitor();
        rsp_t r;
        forever begin
            @(negedge clk_in);
            if (rst_n_in && rsp_valid) rsp_cycles++;
            if (rst_n_in && rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    fail_event("rsp_order", "response with no queued expectation");
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_data", rsp_data, r.data);
                    check("rsp_err", 64'(rsp_err), 64'(r.err));
                    check("rsp_timeout", 64'(rsp_timeout), 64'(r.tmo));
                end
            end
        end
    endtask

    task automatic dv_monitor();
        forever begin
            @(negedge clk_in);
            if (des_in_valid) dv_cycles++;
        end
    endtask

    task automatic push_job(input job_t j, input beh_t b, input rsp_t r);
        int k;
        iss_q.push_back(j);
        beh_q.push_back(b);
        rsp_q.push_back(r);
        req_data = j.data; req_key = j.key; req_mode = j.mode; req_verify = j.verify;
        req_valid = 1'b1;
        k = 0;
        forever begin
            @(negedge clk_in);
            if (req_ready) break;
            k++;
            if (k > 500) break;
        end
        if (k > 500) begin
            check("push_accept", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
        end else begin
            @(posedge clk_in);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 1500; k++) begin
            @(negedge clk_in);
            if (!busy && rsp_q.size() == 0) break;
        end
        if (k >= 1500) check(name, 64'(rsp_q.size()), 64'd0);
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        fork
            core_model();
            rsp_monitor();
            dv_monitor();
        join_none

        // Reset values
        repeat (3) @(negedge clk_in);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_des_in_valid", 64'(des_in_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_des_data", des_data, 64'd0);
        check("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        tick_dummy: repeat (2) @(posedge clk_in);
        #1;

        // Single job, classic DES vector
        dv_cycles = 0;
        push_job(mkj(64'h0123_4567_89AB_CDEF, 64'h1334_5779_9BBC_DFF1, 1'b0, 1'b0),
                 mkb(16, 64'h85E8_1354_0F0A_B405, 1'b0, 0),
                 mkr(64'h85E8_1354_0F0A_B405, 1'b0, 1'b0));
        wait_idle("single_done");
        check("single_dv_cycles", 64'(dv_cycles), 64'd1);

        // Backpressure: the head job moves to the des_* registers, so the FIFO fills on the fifth push
        des_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_job(mkj(64'h1111_0000_0000_0000 + 64'(i), 64'h0E32_9232_EA6D_0D73,
                         1'(i % 2), 1'(i == 2)),
                     mkb(2 + i * 3, 64'hC0DE_0000_0000_0000 + 64'(i * 17), 1'b0, 0),
                     mkr(64'hC0DE_0000_0000_0000 + 64'(i * 17), 1'b0, 1'b0));
            if (i == 3) check("bp_ready_before_full", 64'(req_ready), 64'd1);
            if (i == 4) check("bp_ready_full", 64'(req_ready), 64'd0);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            check("bp_hold_valid", 64'(des_in_valid), 64'd1);
            check("bp_hold_data", des_data, 64'h1111_0000_0000_0000);
        end
        @(posedge clk_in);
        #1;
        des_ready = 1'b1;
        wait_idle("bp_done");

        // Error path
        push_job(mkj(64'hFEDC_BA98_7654_3210, 64'h0101_0101_0101_0100, 1'b1, 1'b1),
                 mkb(5, 64'h0, 1'b1, 0),
                 mkr(64'h0, 1'b1, 1'b0));
        wait_idle("err_done");

        // Result arriving in the expiry cycle wins
        push_job(mkj(64'h2222_3333_4444_5555, 64'h1334_5779_9BBC_DFF1, 1'b0, 1'b0),
                 mkb(TIMEOUT, 64'h1122_3344_5566_7788, 1'b0, 0),
                 mkr(64'h1122_3344_5566_7788, 1'b0, 1'b0));
        wait_idle("race_done");

        // Timeout with a late stray result
        push_job(mkj(64'h0BAD_0BAD_0BAD_0BAD, 64'h1334_5779_9BBC_DFF1, 1'b0, 1'b0),
                 mkb(0, 64'h0, 1'b0, TIMEOUT + 10),
                 mkr(64'h0, 1'b0, 1'b1));
        for (k = 0; k < 100; k++) begin
            if (des_in_valid && des_ready) break;
            @(negedge clk_in);
        end
        @(posedge clk_in);
        k = 0;
        forever begin
            @(posedge clk_in);
            k++;
            @(negedge clk_in);
            if (rsp_valid || k > 200) break;
        end
        check("tmo_latency", 64'(k), 64'(TIMEOUT));
        wait_idle("tmo_done");
        rsp_cycles = 0;
        repeat (20) @(posedge clk_in);
        #1;
        check("late_ignored_rsp", 64'(rsp_cycles), 64'd0);
        check("late_ignored_busy", 64'(busy), 64'd0);

        // Response stall, then reset with jobs queued
        rsp_ready = 1'b0;
        push_job(mkj(64'h3333_4444_5555_6666, 64'h1334_5779_9BBC_DFF1, 1'b0, 1'b0),
                 mkb(4, 64'hA5A5_5A5A_A5A5_5A5A, 1'b0, 0),
                 mkr(64'hA5A5_5A5A_A5A5_5A5A, 1'b0, 1'b0));
        for (k = 0; k < 100; k++) begin
            @(negedge clk_in);
            if (rsp_valid) break;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            check("stall_valid", 64'(rsp_valid), 64'd1);
            check("stall_data", rsp_data, 64'hA5A5_5A5A_A5A5_5A5A);
            check("stall_flags", {62'd0, rsp_err, rsp_timeout}, 64'd0);
        end
        @(posedge clk_in);
        #1;
        for (int i = 0; i < 2; i++) begin
            push_job(mkj(64'h7777_0000_0000_0000 + 64'(i), 64'h1334_5779_9BBC_DFF1, 1'b0, 1'b0),
                     mkb(3, 64'h1, 1'b0, 0), mkr(64'h1, 1'b0, 1'b0));
        end
        check("stall_busy", 64'(busy), 64'd1);
        rst_n_in = 1'b0;
        iss_q.delete();
        beh_q.delete();
        rsp_q.delete();
        @(negedge clk_in);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        rsp_ready = 1'b1;
        dv_cycles = 0;
        repeat (20) @(posedge clk_in);
        #1;
        check("post_rst_no_issue", 64'(dv_cycles), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);

`ifdef DES_REQ_STATS_EN
        check("stat_jobs_rst", 64'(stat_jobs), 64'd0);
        check("stat_errs_rst", 64'(stat_errs), 64'd0);
        check("stat_tmo_rst", 64'(stat_tmo), 64'd0);
        for (int i = 0; i < 3; i++) begin
            push_job(mkj(64'h5555_0000_0000_0000 + 64'(i), 64'h1334_5779_9BBC_DFF1, 1'b0, 1'b0),
                     mkb(2 + i, 64'h9999_0000_0000_0000 + 64'(i), 1'b0, 0),
                     mkr(64'h9999_0000_0000_0000 + 64'(i), 1'b0, 1'b0));
        end
        push_job(mkj(64'h6666_0000_0000_0000, 64'h1334_5779_9BBC_DFF1, 1'b1, 1'b1),
                 mkb(3, 64'h0, 1'b1, 0), mkr(64'h0, 1'b1, 1'b0));
        push_job(mkj(64'h6666_0000_0000_0001, 64'h1334_5779_9BBC_DFF1, 1'b0, 1'b0),
                 mkb(0, 64'h0, 1'b0, 0), mkr(64'h0, 1'b0, 1'b1));
        wait_idle("stats_done");
        check("stat_jobs", 64'(stat_jobs), 64'd5);
        check("stat_errs", 64'(stat_errs), 64'd1);
        check("stat_tmo", 64'(stat_tmo), 64'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
